// File: rtl/sprite_arb_pkg.sv
// Shared types and helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so single-client builds still get a 1-bit index.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// Rotating-priority first-one finder: lowest offset from ptr_i wins.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Scan farthest offset first so the nearest requester overwrites last.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                any_o = 1'b1;
                idx_o = PW'(j);
                gnt_o = N'(1) << j;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sprite ROM arbiter with optional burst lock; one access per cycle.
// Define SPRITE_ARB_PRIO0_EN to give client 0 absolute priority.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int PW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] tag_q, tag_d;
    logic          pvalid_q, pvalid_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [PW-1:0]      rr_idx;
    logic               rr_any;

    logic          win_any;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] ptr_inc;
    logic          from_burst;
    logic          prio0;
    logic          preempt;

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        tag_d      = tag_q;
        pvalid_d   = 1'b0;
        win_any    = 1'b0;
        win_idx    = '0;
        from_burst = 1'b0;
        prio0      = 1'b0;
        preempt    = 1'b0;

`ifdef SPRITE_ARB_PRIO0_EN
        if (req[0]) begin
            win_any    = 1'b1;
            prio0      = 1'b1;
            from_burst = (state_q == BURST) && (owner_q == '0);
            preempt    = (state_q == BURST) && (owner_q != '0) && req[owner_q];
        end else
`endif
        if (state_q == BURST && req[owner_q]) begin
            win_any    = 1'b1;
            win_idx    = owner_q;
            from_burst = 1'b1;
        end else begin
            // Owner went quiet: fall straight into round robin, no bubble.
            win_any = rr_any;
            win_idx = rr_idx;
        end

        ptr_inc = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);

        if (win_any) begin
            tag_d    = win_idx;
            pvalid_d = 1'b1;
            if (!prio0) rr_ptr_d = ptr_inc;
            if (preempt) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (from_burst) begin
                cnt_d = cnt_q + CW'(1);
                if (!lock[win_idx] || (int'(cnt_q) + 1 == MAX_BURST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else if (lock[win_idx] && MAX_BURST > 1) begin
                state_d = BURST;
                owner_d = win_idx;
                cnt_d   = CW'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            tag_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            pvalid_q <= pvalid_d;
        end
    end

    always_comb begin
        gnt      = '0;
        rom_en   = 1'b0;
        rom_addr = '0;
        if (win_any && !rst) begin
            gnt      = NUM_REQ'(1) << win_idx;
            rom_en   = 1'b1;
            rom_addr = addr_in[int'(win_idx)*ADDR_W +: ADDR_W];
        end
    end

    assign rd_valid = pvalid_q ? (NUM_REQ'(1) << tag_q) : '0;
    assign rd_data  = pvalid_q ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized scoreboard bench for sprite_rom_arbiter with directed scenarios up front.
module tb_sprite_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, gnt, rd_valid;
    logic [N*AW-1:0] addr_in;
    logic [DW-1:0]   rd_data, rom_data;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr_in(addr_in),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:16383];
    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard entries: grant cycle, client, byte the ROM holds at that address.
    typedef struct {
        int         gcyc;
        int         cli;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    // Reference model: pointer, burst owner (-1 = none), grants in current burst.
    int         m_rr    = 0;
    int         m_owner = -1;
    int         m_cnt   = 0;
    logic [N-1:0] last_gnt = '0;

    always @(negedge clk) begin
        int w;
        bit pre;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        exp_t e;
        if (rst) begin
            check("gnt in reset", 64'(gnt), 64'(0));
            check("rom_en in reset", 64'(rom_en), 64'(0));
            m_rr = 0; m_owner = -1; m_cnt = 0; last_gnt = '0;
        end else begin
            w = -1; pre = 0; eg = '0; ea = '0;
            if (m_owner >= 0 && !req[m_owner]) begin m_owner = -1; m_cnt = 0; end
`ifdef SPRITE_ARB_PRIO0_EN
            if (req[0]) begin w = 0; if (m_owner > 0) pre = 1; end
`endif
            if (w < 0 && m_owner >= 0) w = m_owner;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
            if (w >= 0) begin
                eg = N'(1) << w;
                ea = addr_in[w*AW +: AW];
                e.gcyc = cyc; e.cli = w; e.data = mem[ea];
                sbq.push_back(e);
                if (pre) begin
                    m_owner = -1; m_cnt = 0;
                end else if (m_owner >= 0 && w == m_owner) begin
                    m_cnt = m_cnt + 1;
                    if (!lock[w] || m_cnt == MB) begin m_owner = -1; m_cnt = 0; end
                end else if (lock[w] && MB > 1) begin
                    m_owner = w; m_cnt = 1;
                end
`ifdef SPRITE_ARB_PRIO0_EN
                if (w != 0) m_rr = (w + 1) % N;
`else
                m_rr = (w + 1) % N;
`endif
            end
            check("gnt", 64'(gnt), 64'(eg));
            check("rom_en", 64'(rom_en), 64'(w >= 0));
            check("rom_addr", 64'(rom_addr), 64'(ea));
            last_gnt = eg;
        end
    end

    // Monitor: every rd_valid must match the grant made one cycle earlier.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid != '0) begin
            if (sbq.size() == 0 || sbq[0].gcyc != cyc - 1) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected rd_valid: got %0h expected none (cycle %0d)", rd_valid, cyc);
            end else begin
                e = sbq.pop_front();
                check("rd_valid", 64'(rd_valid), 64'(N'(1) << e.cli));
                check("rd_data", 64'(rd_data), 64'(e.data));
            end
        end else begin
            check("rd_data idle", 64'(rd_data), 64'(0));
            if (sbq.size() > 0 && sbq[0].gcyc == cyc - 1) begin
                e = sbq.pop_front();
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL missing rd_valid: got 0 expected client %0d (cycle %0d)", e.cli, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; lock = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int run, maxrun;
        logic [N-1:0] exp_g;
        logic [3:0] lk_sched;
        rst = 1'b1; req = '0; lock = '0; addr_in = '0;
        for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
        mem[14'h0123] = 8'h5A;
        tick(); tick(); tick();
        rst = 1'b0;

        // Single request from client 1.
        addr_in[1*AW +: AW] = 14'h0123;
        req = 4'b0010;
        @(negedge clk);
        check("t1 gnt", 64'(gnt), 64'(4'b0010));
        tick();
        req = '0;
        @(negedge clk);
        check("t1 rd_valid", 64'(rd_valid), 64'(4'b0010));
        check("t1 rd_data", 64'(rd_data), 64'(8'h5A));
        tick();

        // All four requesting, no lock: strict rotation from 0.
        do_reset();
        for (int i = 0; i < N; i++) addr_in[i*AW +: AW] = AW'(16'h0100 * (i + 1));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2 rotation", 64'(gnt), 64'(N'(1) << (k % N)));
            tick();
        end
        req = '0;
        tick();

        // Client 2 locked for long, client 0 competing: burst caps at MB.
        do_reset();
        req = 4'b0101; lock = 4'b0100;
        run = 0; maxrun = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (gnt == 4'b0100) run = run + 1;
            else begin if (run > maxrun) maxrun = run; run = 0; end
            tick();
        end
        if (run > maxrun) maxrun = run;
        check("t3 burst length", 64'(maxrun), 64'(MB));
        req = '0; lock = '0;
        tick();

        // Client 1 drops lock on its 3rd grant; client 3 follows without a bubble.
        do_reset();
        req = 4'b1010;
        lk_sched = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            lock = lk_sched[k] ? 4'b0010 : 4'b0000;
            exp_g = (k < 3) ? 4'b0010 : 4'b1000;
            @(negedge clk);
            check("t4 burst exit", 64'(gnt), 64'(exp_g));
            tick();
        end
        req = '0; lock = '0;
        tick();

        // Reset in the middle of traffic.
        req = 4'b1111;
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        check("t5 gnt in rst", 64'(gnt), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5 rd_valid after rst", 64'(rd_valid), 64'(0));
        check("t5 first winner", 64'(gnt), 64'(4'b0001));
        tick();
        req = '0;
        tick();

`ifdef SPRITE_ARB_PRIO0_EN
        // Client 0 preempts client 3's burst after five grants.
        do_reset();
        req = 4'b1000; lock = 4'b1000;
        for (int k = 0; k < 5; k++) tick();
        req = 4'b1001;
        @(negedge clk);
        check("t6 preempt gnt", 64'(gnt), 64'(4'b0001));
        tick();
        req = 4'b1000;
        @(negedge clk);
        check("t6 rd_valid0", 64'(rd_valid), 64'(4'b0001));
        tick();
        req = '0; lock = '0;
        tick();
`endif

        // Random traffic: requests held until granted, occasional row bursts and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (req[i] && last_gnt[i]) begin
                        if ($urandom_range(1) == 0) req[i] = 1'b0;
                        else addr_in[i*AW +: AW] = addr_in[i*AW +: AW] + AW'(1);
                    end else if (!req[i] && $urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        addr_in[i*AW +: AW] = AW'($urandom);
                    end
                    lock[i] = ($urandom_range(3) != 0);
                end
            end
            tick();
        end
        rst = 1'b0; req = '0; lock = '0;
        tick(); tick(); tick();
        check("scoreboard drained", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
